// File: rtl/instr_ctrl_fsm.sv
// Instruction sequencer: fetches one 16-bit word, decodes it into ALU/register-file
// controls, waits out the ALU, then pulses the write-back strobes.
module instr_ctrl_fsm #(
    parameter int          DATA_W     = 16,
    parameter int          ALU_WAIT   = 1,
    parameter bit          SEXT_ARITH = 1'b1,
    parameter logic [15:0] HALT_INSTR = 16'h40F0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [3:0]        rdest_addr,
    output logic [3:0]        rsrc_addr,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] imm,
    output logic              imm_sel,
    output logic              rf_we,
    output logic              flags_we,
    output logic              done,
    output logic              illegal,
    output logic              busy
);

    // state  | meaning
    // FETCH  | waiting for an instruction handshake
    // DECODE | captured word decoded; illegal pulse or halt exit happen here
    // EXEC   | ALU settling, wait_cnt counts down to zero
    // WB     | write-back strobes and done for one cycle
    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_LSH = 4'b0111;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [DATA_W-1:0] SX_MASK = {DATA_W{1'b1}} << 8;

    logic [1:0]        state;
    logic [15:0]       ir;
    logic [3:0]        wait_cnt;
    logic [3:0]        op;
    logic [3:0]        ext;
    logic [3:0]        d_alu;
    logic              d_sel;
    logic              d_legal;
    logic              d_arith;
    logic              d_halt;
    logic [DATA_W-1:0] imm_zx;
    logic [DATA_W-1:0] d_imm;
    logic              active;

    assign op     = ir[15:12];
    assign ext    = ir[7:4];
    assign d_halt = (ir == HALT_INSTR);
    assign imm_zx = DATA_W'(ir[7:0]);

    always_comb begin
        d_alu   = ALU_NOP;
        d_sel   = 1'b0;
        d_legal = 1'b0;
        if (!d_halt) begin
            case (op)
                4'b0000: begin
                    d_legal = 1'b1;
                    case (ext)
                        4'b0101: d_alu = ALU_ADD;
                        4'b1001: d_alu = ALU_SUB;
                        4'b1011: d_alu = ALU_CMP;
                        4'b0001: d_alu = ALU_AND;
                        4'b0010: d_alu = ALU_OR;
                        4'b0011: d_alu = ALU_XOR;
                        default: d_legal = 1'b0;
                    endcase
                end
                4'b1000: begin d_legal = 1'b1; d_alu = ALU_LSH; end
                4'b0101: begin d_legal = 1'b1; d_sel = 1'b1; d_alu = ALU_ADD; end
                4'b1001: begin d_legal = 1'b1; d_sel = 1'b1; d_alu = ALU_SUB; end
                4'b1011: begin d_legal = 1'b1; d_sel = 1'b1; d_alu = ALU_CMP; end
                4'b0001: begin d_legal = 1'b1; d_sel = 1'b1; d_alu = ALU_AND; end
                4'b0010: begin d_legal = 1'b1; d_sel = 1'b1; d_alu = ALU_OR;  end
                4'b0011: begin d_legal = 1'b1; d_sel = 1'b1; d_alu = ALU_XOR; end
                default: ;
            endcase
            if (!d_legal) d_alu = ALU_NOP;
        end
    end

    assign d_arith = d_legal && (d_alu == ALU_ADD || d_alu == ALU_SUB || d_alu == ALU_CMP);

    // Logic-op immediates are always zero-extended; only arithmetic forms may sign-extend.
    always_comb begin
        d_imm = '0;
        if (d_sel) begin
            d_imm = imm_zx;
            if (SEXT_ARITH && d_arith && ir[7]) d_imm = imm_zx | SX_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!d_legal) begin
                        state <= S_FETCH;
                    end else if (ALU_WAIT > 0) begin
                        state    <= S_EXEC;
                        wait_cnt <= 4'(ALU_WAIT - 1);
                    end else begin
                        state <= S_WB;
                    end
                end
                S_EXEC: begin
                    if (wait_cnt == 4'd0) state <= S_WB;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign active = (state != S_FETCH);

    always_comb begin
        instr_ready = (state == S_FETCH) && rst_n;
        busy        = active;
        rdest_addr  = active ? ir[11:8] : 4'd0;
        rsrc_addr   = active ? ir[3:0]  : 4'd0;
        alu_op      = active ? d_alu    : ALU_NOP;
        imm         = active ? d_imm    : '0;
        imm_sel     = active && d_sel;
        done        = (state == S_WB);
        rf_we       = (state == S_WB) && d_legal && (d_alu != ALU_CMP);
        flags_we    = (state == S_WB) && d_arith;
        illegal     = (state == S_DECODE) && !d_legal && !d_halt;
    end

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Bench for instr_ctrl_fsm: three instances (ALU_WAIT 1, 0, 15) checked every cycle
// against a timeline model, plus directed literal expectations.
module tb_instr_ctrl_fsm;

    localparam int N_DUT = 3;

    typedef struct {
        int         kind;   // 0 executes, 1 halt word, 2 illegal
        logic [3:0] alu;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [15:0] imm;
        logic       sel;
        logic       rf;
        logic       fl;
    } dec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [15:0] instr_a [N_DUT];
    logic        valid_a [N_DUT];
    logic        ready_a [N_DUT];
    logic [3:0]  rd_a    [N_DUT];
    logic [3:0]  rs_a    [N_DUT];
    logic [3:0]  alu_a   [N_DUT];
    logic [15:0] imm_a   [N_DUT];
    logic        sel_a   [N_DUT];
    logic        rf_a    [N_DUT];
    logic        fl_a    [N_DUT];
    logic        done_a  [N_DUT];
    logic        ill_a   [N_DUT];
    logic        busy_a  [N_DUT];

    int n_vec = 0;
    int n_err = 0;
    int retired [N_DUT];

    int   cyc = 0;
    int   free_c [N_DUT];
    int   dec_c  [N_DUT];
    int   end_c  [N_DUT];
    int   wb_c   [N_DUT];
    dec_t exp_d  [N_DUT];

    generate
        for (genvar g = 0; g < N_DUT; g++) begin : g_dut
            localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
            instr_ctrl_fsm #(
                .DATA_W(16), .ALU_WAIT(W), .SEXT_ARITH(1'b1), .HALT_INSTR(16'h40F0)
            ) dut (
                .clk(clk), .rst_n(rst_n), .instr(instr_a[g]), .instr_valid(valid_a[g]),
                .instr_ready(ready_a[g]), .rdest_addr(rd_a[g]), .rsrc_addr(rs_a[g]),
                .alu_op(alu_a[g]), .imm(imm_a[g]), .imm_sel(sel_a[g]), .rf_we(rf_a[g]),
                .flags_we(fl_a[g]), .done(done_a[g]), .illegal(ill_a[g]), .busy(busy_a[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    endfunction

    // Opcode table: index in codes[] is also the ALU encoding (ADD..XOR = 0..5).
    function automatic dec_t model_dec(input logic [15:0] w);
        dec_t d;
        int   codes [6];
        int   code;
        int   v;
        codes = '{5, 9, 11, 1, 2, 3};
        d.kind = 2; d.alu = 4'hF; d.rd = w[11:8]; d.rs = w[3:0];
        d.imm = '0; d.sel = 1'b0; d.rf = 1'b0; d.fl = 1'b0;
        if (w == 16'h40F0) begin
            d.kind = 1;
        end else if (w[15:12] == 4'h8) begin
            d.kind = 0; d.alu = 4'h7; d.rf = 1'b1;
        end else begin
            code = (w[15:12] == 4'h0) ? int'(w[7:4]) : int'(w[15:12]);
            for (int i = 0; i < 6; i++) begin
                if (codes[i] == code) begin
                    d.kind = 0;
                    d.alu  = 4'(i);
                    d.rf   = (i != 2);
                    d.fl   = (i < 3);
                    d.sel  = (w[15:12] != 4'h0);
                    if (d.sel) begin
                        v = int'(w[7:0]);
                        if (i < 3 && v >= 128) v = v - 256;
                        d.imm = 16'(v);
                    end
                end
            end
        end
        return d;
    endfunction

    // Timeline model: a handshake ending cycle c puts DECODE at c+1, WB at c+2+W,
    // and the next ready at c+3+W; halt/illegal words free the slot at c+2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_DUT; k++) begin
                free_c[k] <= 0;
                dec_c[k]  <= -100;
                end_c[k]  <= -100;
                wb_c[k]   <= -100;
            end
        end else begin
            for (int k = 0; k < N_DUT; k++) begin
                if (valid_a[k] && cyc >= free_c[k]) begin
                    exp_d[k] <= model_dec(instr_a[k]);
                    dec_c[k] <= cyc + 1;
                    if (model_dec(instr_a[k]).kind == 0) begin
                        wb_c[k]   <= cyc + 2 + wait_of(k);
                        end_c[k]  <= cyc + 2 + wait_of(k);
                        free_c[k] <= cyc + 3 + wait_of(k);
                    end else begin
                        wb_c[k]   <= -100;
                        end_c[k]  <= cyc + 1;
                        free_c[k] <= cyc + 2;
                    end
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N_DUT; k++) begin
            bit in_win;
            in_win = (cyc >= dec_c[k]) && (cyc <= end_c[k]);
            chk($sformatf("instr_ready[%0d]", k), 32'(ready_a[k]), 32'(rst_n && cyc >= free_c[k]));
            chk($sformatf("busy[%0d]", k), 32'(busy_a[k]), 32'(rst_n && cyc < free_c[k]));
            chk($sformatf("done[%0d]", k), 32'(done_a[k]), 32'(rst_n && cyc == wb_c[k]));
            chk($sformatf("rf_we[%0d]", k), 32'(rf_a[k]), 32'(rst_n && cyc == wb_c[k] && exp_d[k].rf));
            chk($sformatf("flags_we[%0d]", k), 32'(fl_a[k]), 32'(rst_n && cyc == wb_c[k] && exp_d[k].fl));
            chk($sformatf("illegal[%0d]", k), 32'(ill_a[k]),
                32'(rst_n && cyc == dec_c[k] && exp_d[k].kind == 2));
            if (rst_n && in_win) begin
                chk($sformatf("alu_op[%0d]", k), 32'(alu_a[k]), 32'(exp_d[k].alu));
                if (exp_d[k].kind == 0) begin
                    chk($sformatf("rdest_addr[%0d]", k), 32'(rd_a[k]), 32'(exp_d[k].rd));
                    chk($sformatf("imm_sel[%0d]", k), 32'(sel_a[k]), 32'(exp_d[k].sel));
                    chk($sformatf("imm[%0d]", k), 32'(imm_a[k]), 32'(exp_d[k].imm));
                    if (!exp_d[k].sel)
                        chk($sformatf("rsrc_addr[%0d]", k), 32'(rs_a[k]), 32'(exp_d[k].rs));
                end
            end
            if (!rst_n) begin
                chk($sformatf("rst alu_op[%0d]", k), 32'(alu_a[k]), 32'hF);
                chk($sformatf("rst imm[%0d]", k), 32'(imm_a[k]), 32'h0);
                chk($sformatf("rst rdest[%0d]", k), 32'({rd_a[k], rs_a[k], 3'b000, sel_a[k]}), 32'h0);
            end
            if (done_a[k] === 1'b1) retired[k]++;
        end
    endtask

    task automatic send(input int k, input logic [15:0] w);
        bit ok;
        ok = 1'b0;
        instr_a[k] = w;
        valid_a[k] = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (ready_a[k] === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_a[k] = 1'b0;
        instr_a[k] = ~w;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake[%0d]: no instr_ready within 60 cycles for %h", k, w);
        end
    endtask

    task automatic wait_done(input int k, output int lat);
        bit hit;
        hit = 1'b0;
        lat = 1;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (done_a[k] === 1'b1) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!hit) begin
            lat = -1;
            n_vec++;
            n_err++;
            $display("FAIL done_wait[%0d]: no done within 40 cycles", k);
        end
    endtask

    task automatic run_stream(input int k, input logic [15:0] words [5], input int n_exec);
        int r0;
        int lat;
        r0 = retired[k];
        for (int i = 0; i < 5; i++) send(k, words[i]);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        lat = retired[k] - r0;
        chk($sformatf("retired count[%0d]", k), 32'(lat), 32'(n_exec));
    endtask

    initial begin
        int lat;
        logic [15:0] s1 [5];
        logic [15:0] s2 [5];
        for (int k = 0; k < N_DUT; k++) begin
            instr_a[k] = '0;
            valid_a[k] = 1'b0;
            retired[k] = 0;
        end
        #1 rst_n = 1'b0;
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
            begin
                @(negedge clk);
                chk("reset instr_ready", 32'(ready_a[0]), 32'h0);
                chk("reset alu_op", 32'(alu_a[0]), 32'hF);
                chk("reset busy", 32'(busy_a[0]), 32'h0);
                @(negedge clk);
                #2 rst_n = 1'b1;

                send(0, 16'h0152);
                chk("first-edge handshake busy", 32'(busy_a[0]), 32'h1);
                wait_done(0, lat);
                chk("ADD latency W=1", 32'(lat), 32'd3);
                chk("ADD rf_we", 32'(rf_a[0]), 32'h1);
                chk("ADD flags_we", 32'(fl_a[0]), 32'h1);
                chk("ADD rdest", 32'(rd_a[0]), 32'h1);
                chk("ADD rsrc", 32'(rs_a[0]), 32'h2);
                chk("ADD alu_op", 32'(alu_a[0]), 32'h0);
                chk("ADD imm_sel", 32'(sel_a[0]), 32'h0);

                send(0, 16'h53F0);
                wait_done(0, lat);
                chk("ADDI imm", 32'(imm_a[0]), 32'hFFF0);
                chk("ADDI imm_sel", 32'(sel_a[0]), 32'h1);
                chk("ADDI rdest", 32'(rd_a[0]), 32'h3);

                send(0, 16'h13F0);
                wait_done(0, lat);
                chk("ANDI imm", 32'(imm_a[0]), 32'h00F0);
                chk("ANDI flags_we", 32'(fl_a[0]), 32'h0);
                chk("ANDI alu_op", 32'(alu_a[0]), 32'h3);

                send(0, 16'hB4A5);
                wait_done(0, lat);
                chk("CMPI flags_we", 32'(fl_a[0]), 32'h1);
                chk("CMPI rf_we", 32'(rf_a[0]), 32'h0);
                chk("CMPI imm", 32'(imm_a[0]), 32'hFFA5);

                send(0, 16'h40F0);
                lat = 1;
                for (int i = 0; i < 10 && ready_a[0] !== 1'b1; i++) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                chk("HALT ready return", 32'(lat), 32'd2);

                send(0, 16'h7000);
                chk("illegal pulse", 32'(ill_a[0]), 32'h1);
                chk("illegal alu_op", 32'(alu_a[0]), 32'hF);
                @(posedge clk);
                #1;
                chk("illegal ready next", 32'(ready_a[0]), 32'h1);
                chk("illegal one cycle", 32'(ill_a[0]), 32'h0);

                send(1, 16'h0152);
                wait_done(1, lat);
                chk("ADD latency W=0", 32'(lat), 32'd2);
                send(2, 16'h0152);
                wait_done(2, lat);
                chk("ADD latency W=15", 32'(lat), 32'd17);

                s1 = '{16'h0394, 16'h258F, 16'h8102, 16'h36FF, 16'h9780};
                run_stream(0, s1, 5);
                s2 = '{16'h258F, 16'h40F0, 16'h36FF, 16'h0000, 16'h0152};
                run_stream(1, s2, 3);
                run_stream(2, s1, 5);

                send(0, 16'h0152);
                @(posedge clk);
                #2;
                chk("EXEC busy before reset", 32'(busy_a[0]), 32'h1);
                rst_n = 1'b0;
                #1;
                chk("rst in EXEC strobes", 32'({rf_a[0], fl_a[0], done_a[0]}), 32'h0);
                chk("rst in EXEC alu_op", 32'(alu_a[0]), 32'hF);
                chk("rst in EXEC busy", 32'(busy_a[0]), 32'h0);
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                send(0, 16'h0394);
                wait_done(0, lat);
                chk("post-reset SUB latency", 32'(lat), 32'd3);
                chk("post-reset SUB rdest", 32'(rd_a[0]), 32'h3);
                chk("post-reset SUB alu_op", 32'(alu_a[0]), 32'h1);

                send(2, 16'h0152);
                wait_done(2, lat);
                #1 rst_n = 1'b0;
                #1;
                chk("rst in WB done", 32'(done_a[2]), 32'h0);
                chk("rst in WB rf_we", 32'(rf_a[2]), 32'h0);
                @(negedge clk);
                #2 rst_n = 1'b1;
                send(2, 16'h53F0);
                wait_done(2, lat);
                chk("post-reset ADDI latency W=15", 32'(lat), 32'd17);
                @(negedge clk);
                #1;
            end
            begin
                #100000;
                n_vec++;
                n_err++;
                $display("FAIL watchdog: run exceeded time limit");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_ctrl_fsm.md
INSTR_CTRL_FSM -- requirements
Module: instr_ctrl_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath/immediate width, legal 8..64.
REQ-002 SHALL have parameter ALU_WAIT, default 1: ALU propagation wait cycles, legal 0..15.
REQ-003 SHALL have parameter SEXT_ARITH, default 1: 1 = sign-extend ADDI/SUBI/CMPI immediates, 0 = zero-extend all immediates.
REQ-004 SHALL have parameter HALT_INSTR, default 16'h40F0: idle instruction word, consumed without effect.
REQ-005 Clk  in  1  single clock; all state changes on rising edge.
REQ-006 Rst  in  1  reset, asynchronous, active-low.
REQ-007 instr  in  16  instruction word: [15:12] op, [11:8] Rdest, [7:4] opext/imm-hi, [3:0] Rsrc/imm-lo.
REQ-008 instr_valid  in  1  instr is valid this cycle.
REQ-009 instr_ready  out  1  block accepts instr this cycle.
REQ-010 rdest_addr  out  4  destination register index.
REQ-011 rsrc_addr  out  4  source register index.
REQ-012 alu_op  out  4  ADD 0000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, LSH 0111, NOP 1111.
REQ-013 imm  out  DATA_W  extended immediate.
REQ-014 imm_sel  out  1  1 = ALU B operand is imm, 0 = Rsrc.
REQ-015 rf_we  out  1  one-cycle register-file write strobe.
REQ-016 flags_we  out  1  one-cycle flag-register write strobe.
REQ-017 done  out  1  one-cycle instruction-retired pulse.
REQ-018 illegal  out  1  one-cycle undecodable-instruction pulse.
REQ-019 busy  out  1  high in every state except FETCH.

Function
REQ-020 States SHALL be FETCH, DECODE, EXEC, WB; one-hot or binary encoding free.
REQ-021 FETCH: instr_ready=1; handshake instr_valid&instr_ready captures instr into an internal register; DECODE next, else stay in FETCH.
REQ-022 All decode SHALL use the captured word only; instr changes after handshake SHALL have no effect.
REQ-023 DECODE, op 0000 (R-type): opext 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR; imm_sel=0.
REQ-024 DECODE, op 1000: alu_op=LSH, imm_sel=0, Rsrc = shift amount register.
REQ-025 DECODE, op 0101/1001/1011/0001/0010/0011: ADDI/SUBI/CMPI/ANDI/ORI/XORI; imm_sel=1; imm = {instr[7:4],instr[3:0]} extended to DATA_W per REQ-003 (logic ops always zero-extended).
REQ-026 Captured word == HALT_INSTR: no strobes, no done, return to FETCH next cycle.
REQ-027 Any other word: illegal=1 for the DECODE cycle, alu_op=NOP, no rf_we/flags_we/done, FETCH next.
REQ-028 DECODE→EXEC if ALU_WAIT>0, else DECODE→WB; EXEC SHALL last exactly ALU_WAIT cycles via down-counter, then WB.
REQ-029 WB lasts one cycle then FETCH; in WB: done=1; rf_we=1 unless CMP/CMPI; flags_we=1 for ADD/SUB/CMP and immediate forms, 0 for AND/OR/XOR/LSH.
REQ-030 rdest_addr, rsrc_addr, alu_op, imm, imm_sel SHALL be stable from DECODE through WB inclusive.
REQ-031 Latency: handshake at cycle N -> WB (rf_we, done) at cycle N+2+ALU_WAIT; next instr_ready at N+3+ALU_WAIT.
REQ-032 rf_we, flags_we, done, illegal SHALL never be high outside their defined state; at most one pulse each per instruction.

Reset
REQ-033 Rst low SHALL immediately force FETCH and clear captured instr, counter, and all outputs to 0, except alu_op=NOP (1111) and instr_ready=1 once Rst is high.
REQ-034 Reset mid-instruction (any state) SHALL discard the instruction with no rf_we/flags_we/done, even if asserted during WB.
REQ-035 First handshake SHALL be possible on the first rising edge after Rst deasserts.

Verification
REQ-036 ALU_WAIT=1: send 16'h0152 (ADD R1,R2) -> rf_we=1, flags_we=1, done=1 exactly 3 cycles after handshake, rdest_addr=1, rsrc_addr=2, alu_op=0000, imm_sel=0.
REQ-037 SEXT_ARITH=1, DATA_W=16: send 16'h53F0 (ADDI R3,#F0) -> imm=16'hFFF0; send 16'h13F0 (ANDI) -> imm=16'h00F0, flags_we=0.
REQ-038 Send 16'hB4A5 (CMPI R4) -> flags_we=1, rf_we=0, done=1; send 16'h40F0 -> no strobes, instr_ready returns after 2 cycles.
REQ-039 Send 16'h7000 -> illegal pulses in DECODE cycle, no rf_we/done, instr_ready high next cycle.
REQ-040 ALU_WAIT=0 and ALU_WAIT=15: ADD latency measured as 2 and 17 cycles; back-to-back valid instructions each retire exactly once in order.
REQ-041 Assert Rst low during EXEC of ADD -> all strobes stay 0, alu_op=1111, busy=0 immediately; next instruction after release executes normally.
